// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, FSM state encoding and the generator tap
//               helper for the rate 1/2, K=3 (7,5 octal) convolutional encoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

   localparam int K      = 3;
   localparam int PAIR_W = 2;

   // Generator taps, MSB applies to the newest bit d(n).
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_TAIL1  = 2'd2,
      ST_TAIL2  = 2'd3
   } state_t;

   // Modulo-2 sum of the taps selected by generator g over the window
   // {d(n), d(n-1), d(n-2)}.
   function automatic logic gen_bit(input logic [K-1:0] g, input logic [K-1:0] win);
      return ^(g & win);
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_branch_out.sv
`default_nettype none
// ============================================================================
// Module      : conv_branch_out
// Description : Combinational branch-output generator. Forms the coded pair
//               {c1,c0} from the current information bit and shift register.
// Ports       : d_i    - current bit d(n)
//               sr_i   - shift register, [0]=d(n-1), [1]=d(n-2)
//               pair_o - coded pair, [1]=G0 output, [0]=G1 output
// Revision    : 1.0 - initial release
// ============================================================================
module conv_branch_out
   import conv_pkg::*;
(
   input  logic              d_i,
   input  logic [K-2:0]      sr_i,
   output logic [PAIR_W-1:0] pair_o
);

   logic [K-1:0] win;

   // Window ordered newest-first so it lines up with the generator taps.
   assign win    = {d_i, sr_i[0], sr_i[1]};
   assign pair_o = {gen_bit(G0, win), gen_bit(G1, win)};

endmodule
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder
// Description : Rate 1/2, K=3 convolutional encoder (G0=7, G1=5 octal) with
//               ready/valid handshakes, two zero tail bits per frame and a
//               synchronous frame abort (refresh).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               refresh           - frame abort, clears state and output
//               data_in, valid_in, last_in, in_ready  - input handshake
//               bit_pair_out, valid_out, last_out, out_ready - output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              refresh,
   input  logic              data_in,
   input  logic              valid_in,
   input  logic              last_in,
   output logic              in_ready,
   output logic [PAIR_W-1:0] bit_pair_out,
   output logic              valid_out,
   output logic              last_out,
   input  logic              out_ready
);

   state_t              state_q;
   logic [K-2:0]        sr_q;
   logic [PAIR_W-1:0]   pair_q;
   logic                valid_q;
   logic                last_q;

   logic                out_free;
   logic                in_tail;
   logic                enc_bit;
   logic [PAIR_W-1:0]   pair_d;

   // Output register can take a new pair if empty or being drained now.
   assign out_free = !valid_q || out_ready;
   assign in_tail  = (state_q == ST_TAIL1) || (state_q == ST_TAIL2);
   // Tail states flush the register with zeros so every frame ends in sr=00.
   assign enc_bit  = in_tail ? 1'b0 : data_in;
   assign in_ready = !rst && !in_tail && out_free;

   conv_branch_out u_branch (
      .d_i    (enc_bit),
      .sr_i   (sr_q),
      .pair_o (pair_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         pair_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (refresh) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         // Drain first; a load below overrides this in the same cycle.
         if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
         case (state_q)
            ST_IDLE, ST_ENCODE: begin
               if (valid_in && in_ready) begin
                  pair_q  <= pair_d;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  sr_q    <= {sr_q[0], enc_bit};
                  state_q <= last_in ? ST_TAIL1 : ST_ENCODE;
               end
            end
            ST_TAIL1: begin
               if (out_free) begin
                  pair_q  <= pair_d;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  sr_q    <= {sr_q[0], enc_bit};
                  state_q <= ST_TAIL2;
               end
            end
            ST_TAIL2: begin
               if (out_free) begin
                  pair_q  <= pair_d;
                  valid_q <= 1'b1;
                  last_q  <= 1'b1;
                  sr_q    <= {sr_q[0], enc_bit};
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bit_pair_out = pair_q;
   assign valid_out    = valid_q;
   assign last_out     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_encoder
// Description : Self-checking bench for conv_encoder. A sequence-level model
//               convolves each accepted frame (plus two zero tail bits) with
//               the 7,5 generators and queues the pairs still owed downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       refresh = 1'b0;
   logic       data_in = 1'b0;
   logic       valid_in = 1'b0;
   logic       last_in = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready;
   logic [1:0] bit_pair_out;
   logic       valid_out;
   logic       last_out;

   always #5 clk = ~clk;

   conv_encoder dut (
      .clk          (clk),
      .rst          (rst),
      .refresh      (refresh),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .last_in      (last_in),
      .in_ready     (in_ready),
      .bit_pair_out (bit_pair_out),
      .valid_out    (valid_out),
      .last_out     (last_out),
      .out_ready    (out_ready)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   string       cur      = "none";

   logic [2:0]  expq[$];     // {last, c1, c0} pairs owed downstream
   logic        fb[$];       // bits of the frame currently being accepted
   logic [31:0] log_pairs;   // pairs actually transferred, oldest at top
   logic [15:0] log_last;
   int          log_cnt;

   // Direct convolution: c1 = u[n]^u[n-1]^u[n-2], c0 = u[n]^u[n-2].
   task automatic model_push(input logic d, input logic l);
      logic u1, u2;
      int   n;
      fb.push_back(d);
      n  = fb.size();
      u1 = (n >= 2) ? fb[n-2] : 1'b0;
      u2 = (n >= 3) ? fb[n-3] : 1'b0;
      expq.push_back({1'b0, d ^ u1 ^ u2, d ^ u2});
      if (l) begin
         for (int t = 0; t < 2; t++) begin
            fb.push_back(1'b0);
            n  = fb.size();
            u1 = fb[n-2];
            u2 = (n >= 3) ? fb[n-3] : 1'b0;
            expq.push_back({(t == 1) ? 1'b1 : 1'b0, u1 ^ u2, u2});
         end
         fb.delete();
      end
   endtask

   task automatic clear_log();
      log_pairs = '0;
      log_last  = '0;
      log_cnt   = 0;
   endtask

   // One clock: drive at negedge, check 1 ns later, update the model for
   // the coming rising edge.
   task automatic cycle(input logic v, input logic d, input logic l,
                        input logic ordy, input logic rf, input logic rs,
                        output logic acc);
      logic exp_v, exp_r;
      @(negedge clk);
      valid_in = v; data_in = d; last_in = l;
      out_ready = ordy; refresh = rf; rst = rs;
      #1;
      exp_v = (expq.size() != 0);
      exp_r = !rs && ((expq.size() == 0) || (expq.size() == 1 && ordy));
      n_checks++;
      if (valid_out !== exp_v) begin
         n_fail++;
         $display("FAIL %s valid_out: got %b want %b at %0t", cur, valid_out, exp_v, $time);
      end
      n_checks++;
      if (in_ready !== exp_r) begin
         n_fail++;
         $display("FAIL %s in_ready: got %b want %b at %0t", cur, in_ready, exp_r, $time);
      end
      n_checks++;
      if (exp_v) begin
         if ({last_out, bit_pair_out} !== expq[0]) begin
            n_fail++;
            $display("FAIL %s pair/last: got %b%b want %b at %0t",
                     cur, last_out, bit_pair_out, expq[0], $time);
         end
      end else if (last_out !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle last_out: got %b want 0 at %0t", cur, last_out, $time);
      end
      acc = v && in_ready && !rf && !rs;
      if (rs || rf) begin
         expq.delete();
         fb.delete();
      end else begin
         if (valid_out && ordy) begin
            log_pairs = {log_pairs[29:0], bit_pair_out};
            log_last  = {log_last[14:0], last_out};
            log_cnt++;
         end
         if (exp_v && ordy) void'(expq.pop_front());
         if (acc) model_push(d, l);
      end
   endtask

   // Feeds bits[0..n-1]; out_ready drops for stall_len cycles from stall_at;
   // refresh on cycle rf_at aborts the frame; then drain idle cycles.
   task automatic run_frame(input logic [15:0] bits, input int n,
                            input int stall_at, input int stall_len,
                            input int rf_at, input int drain);
      int   i = 0;
      int   k = 0;
      logic acc, ordy, rf;
      while (i < n && k < 100) begin
         ordy = !(k >= stall_at && k < stall_at + stall_len);
         rf   = (k == rf_at);
         cycle(1'b1, bits[i], (i == n-1), ordy, rf, 1'b0, acc);
         k++;
         if (rf) break;
         if (acc) i++;
      end
      if (k >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s input timeout: accepted %0d want %0d", cur, i, n);
      end
      for (int j = 0; j < drain; j++) begin
         ordy = !(k >= stall_at && k < stall_at + stall_len);
         cycle(1'b0, 1'b0, 1'b0, ordy, 1'b0, 1'b0, acc);
         k++;
      end
   endtask

   task automatic test_reset();
      logic acc;
      cur = "reset";
      rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1; refresh = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (bit_pair_out !== 2'b00) begin n_fail++; $display("FAIL reset pair: got %b want 00", bit_pair_out); end
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
      n_checks++;
      if (last_out !== 1'b0) begin n_fail++; $display("FAIL reset last_out: got %b want 0", last_out); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
      expq.delete();
      fb.delete();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset release in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      cur = "basic";
      clear_log();
      run_frame(16'b1101, 4, -1, 0, -1, 4);
      n_checks++;
      if (log_cnt != 6 || log_pairs[11:0] !== 12'b11_10_00_01_01_11) begin
         n_fail++;
         $display("FAIL basic sequence: got %0d pairs %b want 6 pairs 111000010111", log_cnt, log_pairs[11:0]);
      end
      n_checks++;
      if (log_last[5:0] !== 6'b000001) begin
         n_fail++;
         $display("FAIL basic last flags: got %b want 000001", log_last[5:0]);
      end
   endtask

   task automatic test_single_zero();
      cur = "single";
      clear_log();
      run_frame(16'b0, 1, -1, 0, -1, 4);
      n_checks++;
      if (log_cnt != 3 || log_pairs[5:0] !== 6'b00_00_00 || log_last[2:0] !== 3'b001) begin
         n_fail++;
         $display("FAIL single frame: got %0d pairs %b last %b want 3 pairs 000000 last 001",
                  log_cnt, log_pairs[5:0], log_last[2:0]);
      end
   endtask

   task automatic test_stall();
      cur = "stall";
      clear_log();
      run_frame(16'b1101, 4, 2, 3, -1, 4);
      n_checks++;
      if (log_cnt != 6 || log_pairs[11:0] !== 12'b11_10_00_01_01_11 || log_last[5:0] !== 6'b000001) begin
         n_fail++;
         $display("FAIL stall sequence: got %0d pairs %b last %b want 111000010111 last 000001",
                  log_cnt, log_pairs[11:0], log_last[5:0]);
      end
   endtask

   task automatic test_refresh();
      cur = "refresh";
      clear_log();
      run_frame(16'b1101, 4, -1, 0, 2, 2);
      clear_log();
      run_frame(16'b1101, 4, -1, 0, -1, 4);
      n_checks++;
      if (log_cnt != 6 || log_pairs[11:0] !== 12'b11_10_00_01_01_11 || log_last[5:0] !== 6'b000001) begin
         n_fail++;
         $display("FAIL refresh follow-up: got %0d pairs %b last %b want 111000010111 last 000001",
                  log_cnt, log_pairs[11:0], log_last[5:0]);
      end
   endtask

   task automatic test_rst_tail();
      logic acc;
      cur = "rst_tail";
      clear_log();
      run_frame(16'b1101, 4, -1, 0, -1, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      n_checks++;
      if (bit_pair_out !== 2'b00 || last_out !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_tail outputs: got pair %b last %b rdy %b want 00 0 1",
                  bit_pair_out, last_out, in_ready);
      end
      n_checks++;
      if (log_cnt != 3 || log_last !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_tail emitted: got %0d pairs last %b want 3 pairs no last", log_cnt, log_last);
      end
   endtask

   task automatic test_back_to_back();
      cur = "b2b";
      clear_log();
      run_frame(16'b11, 2, -1, 0, -1, 0);
      run_frame(16'b01, 2, -1, 0, -1, 4);
      n_checks++;
      if (log_cnt != 8 || log_pairs[15:0] !== 16'b11_01_01_11_11_10_11_00 ||
          log_last[7:0] !== 8'b0001_0001) begin
         n_fail++;
         $display("FAIL b2b sequence: got %0d pairs %b last %b want 1101011111101100 last 00010001",
                  log_cnt, log_pairs[15:0], log_last[7:0]);
      end
   endtask

   task automatic test_random();
      logic acc, v, ordy, rf;
      logic [15:0] bits;
      int   n, i, k;
      cur = "random";
      for (int f = 0; f < 40; f++) begin
         n    = $urandom_range(1, 8);
         bits = 16'($urandom);
         i    = 0;
         k    = 0;
         while (i < n && k < 200) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            rf   = ($urandom_range(0, 49) == 0);
            cycle(v, bits[i], (i == n-1), ordy, rf, 1'b0, acc);
            k++;
            if (rf) break;
            if (acc) i++;
         end
         if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL random input timeout in frame %0d", f);
         end
      end
      for (int j = 0; j < 8; j++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_zero();
      test_stall();
      test_refresh();
      test_rst_tail();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 refresh  input  1  synchronous frame abort; clears encoder state and pending output.
REQ-004 data_in  input  1  information bit.
REQ-005 valid_in  input  1  data_in/last_in valid.
REQ-006 last_in  input  1  marks final information bit of frame.
REQ-007 in_ready  output  1  encoder accepts data_in this cycle.
REQ-008 bit_pair_out  output  2  coded pair; [1]=G0 output, [0]=G1 output.
REQ-009 valid_out  output  1  bit_pair_out/last_out valid.
REQ-010 last_out  output  1  marks final coded pair of frame (second tail pair).
REQ-011 out_ready  input  1  downstream (BMU chain) accepts pair this cycle.

Function
REQ-012 Code SHALL be rate 1/2, K=3, generators G0=111, G1=101 (octal 7,5); 4 trellis states.
REQ-013 Shift register sr[1:0]: sr[0]=d(n-1), sr[1]=d(n-2); c1=d^sr[0]^sr[1], c0=d^sr[1]; bit_pair_out={c1,c0}.
REQ-014 Input transfer SHALL occur when valid_in && in_ready; output transfer when valid_out && out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE/ENCODE with (!valid_out || out_ready), and 0 during rst, TAIL1, TAIL2.
REQ-016 Latency: accepted bit SHALL appear on bit_pair_out the next cycle (registered output).
REQ-017 While valid_out && !out_ready, bit_pair_out, last_out, sr and FSM state SHALL hold unchanged.
REQ-018 FSM states IDLE, ENCODE, TAIL1, TAIL2.
REQ-019 IDLE: on transfer with last_in=0 -> ENCODE; with last_in=1 -> TAIL1.
REQ-020 ENCODE: on transfer with last_in=1 -> TAIL1; otherwise stay.
REQ-021 TAIL1: when output register free, encode d=0 (last_out=0), -> TAIL2.
REQ-022 TAIL2: when output register free, encode d=0 with last_out=1, -> IDLE; sr SHALL then be 00.
REQ-023 Each frame SHALL start from sr=00 and yield N+2 pairs for N information bits.
REQ-024 refresh=1: FSM->IDLE, sr->00, valid_out->0, last_out->0 next cycle; concurrent input transfer discarded; pending pair dropped.
REQ-025 rst SHALL take priority over refresh; refresh over any transfer.
REQ-026 valid_out SHALL clear after output transfer unless a new pair is loaded in the same cycle (back-to-back throughput one pair/cycle).

Reset
REQ-027 On rst: FSM=IDLE, sr=00, bit_pair_out=00, valid_out=0, last_out=0, in_ready=0.
REQ-028 First cycle after rst deassertion: in_ready=1.
REQ-029 Reset mid-frame SHALL discard the frame; no tail pairs emitted.

Structure
REQ-030 Shared package conv_pkg SHALL hold K=3, G0=3'b111, G1=3'b101, pair width 2, FSM state encoding.
REQ-031 One combinational sub-module conv_branch_out SHALL compute {c1,c0} from d and sr; the rest is in conv_encoder.

Verification
REQ-032 Frame 1,0,1,1 (last on 4th), out_ready=1 -> pairs 11,10,00,01,01,11; last_out only on final 11; in_ready=0 for two tail cycles.
REQ-033 Single-bit frame d=0 with last_in=1 -> pairs 00,00,00, last_out on third; sr=00 at end.
REQ-034 Same frame as REQ-032 with out_ready low for 3 cycles after 2nd pair -> 10 held stable, in_ready=0 while stalled, sequence unchanged.
REQ-035 refresh pulse after 2nd input bit -> valid_out=0 next cycle; next frame 1,0,1,1 reproduces REQ-032 exactly.
REQ-036 rst asserted during TAIL1 -> all outputs at reset values next cycle, no last_out, in_ready=1 after release.
REQ-037 Back-to-back frames 1,1 then 1,0 with continuous valid_in -> 11,01,01,11 then 11,10,11,00 with no gap except tail stalls.
